tlk2711_rx_framer: RTL and testbench

TLK2711_RX_FRAMER -- requirements
Module: tlk2711_rx_framer

---
 rtl/tlk2711_rx_framer.sv | 252 +++++++++++++++++++++++++
 tb/tb_tlk2711_rx_framer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_rx_framer.sv
// tlk2711_rx_framer: word sync, frame delineation and payload pattern check
// for one TLK2711 receive lane.
// Stage 1 registers the raw word together with i_check_en and i_clr, so both
// controls act on the word they were presented with. Stage 2 decodes that word
// and registers every output, giving two rx_clk cycles of latency.
module tlk2711_rx_framer #(
    parameter int SYNC_CNT = 4,
    parameter int MAX_LEN  = 1024
) (
    input  logic        rx_clk,
    input  logic        rst,
    input  logic [15:0] i_rxd,
    input  logic        i_rkmsb,
    input  logic        i_rklsb,
    input  logic        i_check_en,
    input  logic        i_clr,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_link_up,
    output logic [15:0] o_frame_len,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_err_cnt,
    output logic        o_pat_err,
    output logic        o_frm_err
);

    localparam logic [1:0]  ST_UNSYNC = 2'd0;
    localparam logic [1:0]  ST_IDLE   = 2'd1;
    localparam logic [1:0]  ST_FRAME  = 2'd2;

    localparam logic [2:0]  W_IDLE = 3'd0;
    localparam logic [2:0]  W_SOF  = 3'd1;
    localparam logic [2:0]  W_EOF  = 3'd2;
    localparam logic [2:0]  W_DATA = 3'd3;
    localparam logic [2:0]  W_INV  = 3'd4;

    localparam logic [7:0]  SYNC_LIM = 8'(SYNC_CNT);
    localparam logic [15:0] LEN_LIM  = 16'(MAX_LEN);

    // Map the K flags {msb,lsb} and the data word onto a word class.
    function automatic logic [2:0] classify(input logic [1:0] k, input logic [15:0] d);
        logic [2:0] c;
        case (k)
            2'b00:   c = W_DATA;
            2'b01:   c = (d == 16'hC5BC) ? W_IDLE : W_INV;
            2'b11: begin
                if (d == 16'hFBBC) begin
                    c = W_SOF;
                end else if (d == 16'hFDBC) begin
                    c = W_EOF;
                end else begin
                    c = W_INV;
                end
            end
            default: c = W_INV;
        endcase
        return c;
    endfunction

    logic [15:0] rxd_r;
    logic [1:0]  rk_r;
    logic        check_en_r;
    logic        clr_r;
    logic [1:0]  state_r;
    logic [7:0]  sync_r;
    logic [7:0]  loss_r;
    logic [15:0] len_r;
    logic [15:0] exp_r;

    logic [2:0]  cls_s;
    logic [1:0]  state_nxt_s;
    logic [7:0]  sync_nxt_s;
    logic [7:0]  loss_nxt_s;
    logic [15:0] len_nxt_s;
    logic [15:0] exp_nxt_s;
    logic [15:0] data_s;
    logic        valid_s;
    logic        sof_s;
    logic        eof_s;
    logic        pat_s;
    logic        frm_s;
    logic [15:0] flen_s;
    logic [15:0] fcnt_s;
    logic [15:0] ecnt_s;

    assign cls_s = classify(rk_r, rxd_r);

    // Input stage: capture the raw lane word and its per-word controls.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            rxd_r      <= 16'h0000;
            rk_r       <= 2'b00;
            check_en_r <= 1'b0;
            clr_r      <= 1'b0;
        end else begin
            rxd_r      <= i_rxd;
            rk_r       <= {i_rkmsb, i_rklsb};
            check_en_r <= i_check_en;
            clr_r      <= i_clr;
        end
    end

    // Sync/framing decision for the word held in the input stage.
    always_comb begin
        state_nxt_s = state_r;
        sync_nxt_s  = 8'd0;
        loss_nxt_s  = 8'd0;
        len_nxt_s   = len_r;
        exp_nxt_s   = exp_r;
        data_s      = 16'h0000;
        valid_s     = 1'b0;
        sof_s       = 1'b0;
        eof_s       = 1'b0;
        pat_s       = 1'b0;
        frm_s       = 1'b0;
        flen_s      = o_frame_len;
        case (state_r)
            ST_UNSYNC: begin
                if (cls_s == W_IDLE) begin
                    if (sync_r + 8'd1 == SYNC_LIM) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        sync_nxt_s = sync_r + 8'd1;
                    end
                end else begin
                    sync_nxt_s = 8'd0;
                end
            end
            ST_IDLE: begin
                case (cls_s)
                    W_IDLE: state_nxt_s = ST_IDLE;
                    W_SOF: begin
                        state_nxt_s = ST_FRAME;
                        len_nxt_s   = 16'h0000;
                        exp_nxt_s   = 16'h0000;
                    end
                    default: frm_s = 1'b1;
                endcase
            end
            ST_FRAME: begin
                case (cls_s)
                    W_DATA: begin
                        if (len_r == LEN_LIM) begin
                            // Oversize frame: drop the word and abandon the frame.
                            frm_s       = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            valid_s   = 1'b1;
                            data_s    = rxd_r;
                            sof_s     = (len_r == 16'h0000);
                            len_nxt_s = len_r + 16'd1;
                            exp_nxt_s = rxd_r + 16'd1;
                            if (check_en_r && (rxd_r != exp_r)) begin
                                pat_s = 1'b1;
                            end else begin
                                pat_s = 1'b0;
                            end
                        end
                    end
                    W_EOF: begin
                        eof_s       = 1'b1;
                        flen_s      = len_r;
                        state_nxt_s = ST_IDLE;
                    end
                    W_SOF: begin
                        frm_s     = 1'b1;
                        len_nxt_s = 16'h0000;
                        exp_nxt_s = 16'h0000;
                    end
                    default: begin
                        frm_s       = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                endcase
            end
            default: state_nxt_s = ST_UNSYNC;
        endcase
        // Loss of sync overrides the per-state decision; an open frame is dropped silently.
        if ((state_r != ST_UNSYNC) && (cls_s == W_INV)) begin
            if (loss_r + 8'd1 == SYNC_LIM) begin
                state_nxt_s = ST_UNSYNC;
                len_nxt_s   = 16'h0000;
                exp_nxt_s   = 16'h0000;
            end else begin
                loss_nxt_s = loss_r + 8'd1;
            end
        end else begin
            loss_nxt_s = 8'd0;
        end
    end

    // Saturating statistics; a clear beats an increment on the same word.
    always_comb begin
        fcnt_s = o_frame_cnt;
        ecnt_s = o_err_cnt;
        if (clr_r) begin
            fcnt_s = 16'h0000;
            ecnt_s = 16'h0000;
        end else begin
            if (eof_s && (o_frame_cnt != 16'hFFFF)) begin
                fcnt_s = o_frame_cnt + 16'd1;
            end else begin
                fcnt_s = o_frame_cnt;
            end
            if ((frm_s || pat_s) && (o_err_cnt != 16'hFFFF)) begin
                ecnt_s = o_err_cnt + 16'd1;
            end else begin
                ecnt_s = o_err_cnt;
            end
        end
    end

    // Decode stage: commit state and register every output.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state_r     <= ST_UNSYNC;
            sync_r      <= 8'd0;
            loss_r      <= 8'd0;
            len_r       <= 16'h0000;
            exp_r       <= 16'h0000;
            o_data      <= 16'h0000;
            o_valid     <= 1'b0;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_link_up   <= 1'b0;
            o_frame_len <= 16'h0000;
            o_frame_cnt <= 16'h0000;
            o_err_cnt   <= 16'h0000;
            o_pat_err   <= 1'b0;
            o_frm_err   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            sync_r      <= sync_nxt_s;
            loss_r      <= loss_nxt_s;
            len_r       <= len_nxt_s;
            exp_r       <= exp_nxt_s;
            o_data      <= data_s;
            o_valid     <= valid_s;
            o_sof       <= sof_s;
            o_eof       <= eof_s;
            o_link_up   <= (state_nxt_s != ST_UNSYNC);
            o_frame_len <= flen_s;
            o_frame_cnt <= fcnt_s;
            o_err_cnt   <= ecnt_s;
            o_pat_err   <= pat_s & ~frm_s;
            o_frm_err   <= frm_s;
        end
    end

endmodule

// File: tb/tb_tlk2711_rx_framer.sv
// Bench for tlk2711_rx_framer: two instances (MAX_LEN 1024 and 4) share one
// directed word stream; a word-level model predicts every output cycle and a
// few literal expectations pin the model at the end of each scenario.
`timescale 1ns/1ps
module tb_tlk2711_rx_framer;

    localparam logic [1:0]  K_DATA = 2'b00;
    localparam logic [1:0]  K_IDLE = 2'b01;
    localparam logic [1:0]  K_BAD  = 2'b10;
    localparam logic [1:0]  K_CTRL = 2'b11;
    localparam logic [15:0] V_IDLE = 16'hC5BC;
    localparam logic [15:0] V_SOF  = 16'hFBBC;
    localparam logic [15:0] V_EOF  = 16'hFDBC;

    typedef struct packed {
        logic [15:0] data;
        logic        valid;
        logic        sof;
        logic        eof;
        logic        link;
        logic        pat;
        logic        frm;
        logic [15:0] flen;
        logic [15:0] fcnt;
        logic [15:0] ecnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] i_rxd = 16'h0000;
    logic        i_rkmsb = 1'b0;
    logic        i_rklsb = 1'b0;
    logic        i_check_en = 1'b0;
    logic        i_clr = 1'b0;

    logic [1:0][15:0] o_data;
    logic [1:0]       o_valid;
    logic [1:0]       o_sof;
    logic [1:0]       o_eof;
    logic [1:0]       o_link_up;
    logic [1:0][15:0] o_frame_len;
    logic [1:0][15:0] o_frame_cnt;
    logic [1:0][15:0] o_err_cnt;
    logic [1:0]       o_pat_err;
    logic [1:0]       o_frm_err;

    int checks = 0;
    int failures = 0;

    // model state, one slot per instance
    int          max_len[2] = '{1024, 4};
    bit          m_link[2];
    bit          m_frame[2];
    int          m_run[2];
    int          m_bad[2];
    int          m_len[2];
    logic [15:0] m_exp[2];
    int          m_flen[2];
    int          m_fcnt[2];
    int          m_ecnt[2];
    exp_t        eq0[$];
    exp_t        eq1[$];

    // pulse tallies taken from the DUT, used by the literal checks
    int n_valid[2];
    int n_sof[2];
    int n_eof[2];
    int n_pat[2];
    int n_frm[2];

    always #5 clk = ~clk;

    tlk2711_rx_framer #(.SYNC_CNT(4), .MAX_LEN(1024)) dut_a (
        .rx_clk(clk), .rst(rst), .i_rxd(i_rxd), .i_rkmsb(i_rkmsb), .i_rklsb(i_rklsb),
        .i_check_en(i_check_en), .i_clr(i_clr),
        .o_data(o_data[0]), .o_valid(o_valid[0]), .o_sof(o_sof[0]), .o_eof(o_eof[0]),
        .o_link_up(o_link_up[0]), .o_frame_len(o_frame_len[0]), .o_frame_cnt(o_frame_cnt[0]),
        .o_err_cnt(o_err_cnt[0]), .o_pat_err(o_pat_err[0]), .o_frm_err(o_frm_err[0])
    );

    tlk2711_rx_framer #(.SYNC_CNT(4), .MAX_LEN(4)) dut_b (
        .rx_clk(clk), .rst(rst), .i_rxd(i_rxd), .i_rkmsb(i_rkmsb), .i_rklsb(i_rklsb),
        .i_check_en(i_check_en), .i_clr(i_clr),
        .o_data(o_data[1]), .o_valid(o_valid[1]), .o_sof(o_sof[1]), .o_eof(o_eof[1]),
        .o_link_up(o_link_up[1]), .o_frame_len(o_frame_len[1]), .o_frame_cnt(o_frame_cnt[1]),
        .o_err_cnt(o_err_cnt[1]), .o_pat_err(o_pat_err[1]), .o_frm_err(o_frm_err[1])
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic byte word_class(input logic [1:0] k, input logic [15:0] d);
        if (k == K_DATA) return "D";
        if (k == K_IDLE && d == V_IDLE) return "I";
        if (k == K_CTRL && d == V_SOF) return "S";
        if (k == K_CTRL && d == V_EOF) return "E";
        return "X";
    endfunction

    // Apply the framing rules to one received word and queue the expected outputs.
    task automatic model_step(input int i, input logic [1:0] k, input logic [15:0] d,
                              input logic chk, input logic clr, input logic r);
        exp_t e;
        byte  c;
        bit   frm;
        bit   pat;
        e = '0;
        frm = 1'b0;
        pat = 1'b0;
        if (r) begin
            m_link[i] = 0; m_frame[i] = 0; m_run[i] = 0; m_bad[i] = 0;
            m_len[i] = 0; m_exp[i] = 16'h0000; m_flen[i] = 0; m_fcnt[i] = 0; m_ecnt[i] = 0;
            // the word already in flight is flushed by the reset as well
            if (i == 0 && eq0.size() > 0) eq0[eq0.size()-1] = '0;
            if (i == 1 && eq1.size() > 0) eq1[eq1.size()-1] = '0;
        end else begin
            c = word_class(k, d);
            if (!m_link[i]) begin
                if (c == "I") begin
                    m_run[i]++;
                    if (m_run[i] == 4) begin
                        m_link[i] = 1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end else begin
                if (m_frame[i]) begin
                    if (c == "D") begin
                        if (m_len[i] == max_len[i]) begin
                            frm = 1; m_frame[i] = 0;
                        end else begin
                            e.valid = 1; e.data = d; e.sof = (m_len[i] == 0);
                            pat = chk && (d != m_exp[i]);
                            m_exp[i] = d + 16'd1;
                            m_len[i]++;
                        end
                    end else if (c == "E") begin
                        e.eof = 1; m_flen[i] = m_len[i]; m_frame[i] = 0;
                        if (m_fcnt[i] < 65535) m_fcnt[i]++;
                    end else if (c == "S") begin
                        frm = 1; m_len[i] = 0; m_exp[i] = 16'h0000;
                    end else begin
                        frm = 1; m_frame[i] = 0;
                    end
                end else if (c == "S") begin
                    m_frame[i] = 1; m_len[i] = 0; m_exp[i] = 16'h0000;
                end else if (c != "I") begin
                    frm = 1;
                end
                if (c == "X") begin
                    m_bad[i]++;
                    if (m_bad[i] == 4) begin
                        m_link[i] = 0; m_frame[i] = 0; m_bad[i] = 0;
                    end
                end else begin
                    m_bad[i] = 0;
                end
                if ((frm || pat) && m_ecnt[i] < 65535) m_ecnt[i]++;
            end
            if (clr) begin
                m_fcnt[i] = 0;
                m_ecnt[i] = 0;
            end
            e.frm  = frm;
            e.pat  = pat && !frm;
            e.link = m_link[i];
            e.flen = 16'(m_flen[i]);
            e.fcnt = 16'(m_fcnt[i]);
            e.ecnt = 16'(m_ecnt[i]);
        end
        if (i == 0) eq0.push_back(e);
        else eq1.push_back(e);
    endtask

    task automatic compare_inst(input int i, input exp_t e);
        string p;
        p = (i == 0) ? "a" : "b";
        check({p, ".valid"}, 16'(o_valid[i]), 16'(e.valid));
        if (e.valid) check({p, ".data"}, o_data[i], e.data);
        check({p, ".sof"}, 16'(o_sof[i]), 16'(e.sof));
        check({p, ".eof"}, 16'(o_eof[i]), 16'(e.eof));
        check({p, ".link_up"}, 16'(o_link_up[i]), 16'(e.link));
        check({p, ".pat_err"}, 16'(o_pat_err[i]), 16'(e.pat));
        check({p, ".frm_err"}, 16'(o_frm_err[i]), 16'(e.frm));
        check({p, ".frame_len"}, o_frame_len[i], e.flen);
        check({p, ".frame_cnt"}, o_frame_cnt[i], e.fcnt);
        check({p, ".err_cnt"}, o_err_cnt[i], e.ecnt);
    endtask

    // Compare process: each word's expectation matures two cycles after it was driven.
    always @(negedge clk) begin
        if (eq0.size() == 3) compare_inst(0, eq0.pop_front());
        if (eq1.size() == 3) compare_inst(1, eq1.pop_front());
        for (int j = 0; j < 2; j++) begin
            n_valid[j] += int'(o_valid[j] === 1'b1);
            n_sof[j]   += int'(o_sof[j] === 1'b1);
            n_eof[j]   += int'(o_eof[j] === 1'b1);
            n_pat[j]   += int'(o_pat_err[j] === 1'b1);
            n_frm[j]   += int'(o_frm_err[j] === 1'b1);
        end
    end

    task automatic drive(input logic [1:0] k, input logic [15:0] d, input logic clr, input logic r);
        @(posedge clk);
        #1;
        rst = r;
        i_rkmsb = k[1];
        i_rklsb = k[0];
        i_rxd = d;
        i_clr = clr;
        for (int i = 0; i < 2; i++) model_step(i, k, d, i_check_en, clr, r);
    endtask

    task automatic w(input logic [1:0] k, input logic [15:0] d);
        drive(k, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) w(K_IDLE, V_IDLE);
    endtask

    // Two filler words, then stop just after the last real word's outputs appear.
    task automatic settle(input logic [1:0] k, input logic [15:0] d);
        w(k, d);
        w(k, d);
        @(negedge clk);
        #1;
    endtask

    task automatic clear_tallies();
        for (int j = 0; j < 2; j++) begin
            n_valid[j] = 0; n_sof[j] = 0; n_eof[j] = 0; n_pat[j] = 0; n_frm[j] = 0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        repeat (3) drive(K_DATA, 16'h0000, 1'b0, 1'b1);
        settle(K_DATA, 16'h0000);
        check("reset.link_up", 16'(o_link_up[0]), 16'd0);
        check("reset.frame_cnt", o_frame_cnt[0], 16'd0);
        check("reset.err_cnt", o_err_cnt[0], 16'd0);

        // interrupted idle run never syncs
        idle(3); w(K_DATA, 16'h0055); idle(3);
        settle(K_DATA, 16'h0000);
        check("broken_run.link_up", 16'(o_link_up[0]), 16'd0);

        // 20 idles: link up exactly two cycles after the 4th
        idle(4);
        w(K_IDLE, V_IDLE);
        @(negedge clk); #1;
        check("sync.link_before", 16'(o_link_up[0]), 16'd0);
        w(K_IDLE, V_IDLE);
        @(negedge clk); #1;
        check("sync.link_after", 16'(o_link_up[0]), 16'd1);
        idle(14);

        // good 8-word frame with pattern check; instance b aborts at word 4
        i_check_en = 1'b1;
        clear_tallies();
        w(K_CTRL, V_SOF);
        for (int v = 0; v < 8; v++) w(K_DATA, 16'(v));
        w(K_CTRL, V_EOF);
        settle(K_IDLE, V_IDLE);
        check("frame8.valid_cnt", 16'(n_valid[0]), 16'd8);
        check("frame8.sof_cnt", 16'(n_sof[0]), 16'd1);
        check("frame8.eof_cnt", 16'(n_eof[0]), 16'd1);
        check("frame8.frame_len", o_frame_len[0], 16'd8);
        check("frame8.frame_cnt", o_frame_cnt[0], 16'd1);
        check("frame8.err_cnt", o_err_cnt[0], 16'd0);
        check("frame8.b_valid_cnt", 16'(n_valid[1]), 16'd4);
        check("frame8.b_err_cnt", o_err_cnt[1], 16'd5);

        // pattern break 0,1,5,6: one error on 5 only
        drive(K_IDLE, V_IDLE, 1'b1, 1'b0);
        clear_tallies();
        w(K_CTRL, V_SOF);
        w(K_DATA, 16'd0); w(K_DATA, 16'd1); w(K_DATA, 16'd5); w(K_DATA, 16'd6);
        w(K_CTRL, V_EOF);
        settle(K_IDLE, V_IDLE);
        check("pat.pat_cnt", 16'(n_pat[0]), 16'd1);
        check("pat.err_cnt", o_err_cnt[0], 16'd1);
        check("pat.frame_cnt", o_frame_cnt[0], 16'd1);

        // check disabled: arbitrary payload is not flagged
        i_check_en = 1'b0;
        w(K_CTRL, V_SOF); w(K_DATA, 16'h0003); w(K_DATA, 16'h0009); w(K_CTRL, V_EOF);
        settle(K_IDLE, V_IDLE);
        check("nochk.pat_cnt", 16'(n_pat[0]), 16'd1);
        check("nochk.frame_len", o_frame_len[0], 16'd2);

        // oversize frame on instance b (MAX_LEN 4), then stray EOF
        i_check_en = 1'b1;
        drive(K_IDLE, V_IDLE, 1'b1, 1'b0);
        clear_tallies();
        w(K_CTRL, V_SOF);
        for (int v = 0; v < 5; v++) w(K_DATA, 16'(v));
        w(K_CTRL, V_EOF);
        settle(K_IDLE, V_IDLE);
        check("maxlen.b_valid_cnt", 16'(n_valid[1]), 16'd4);
        check("maxlen.b_frm_cnt", 16'(n_frm[1]), 16'd2);
        check("maxlen.b_eof_cnt", 16'(n_eof[1]), 16'd0);
        check("maxlen.b_frame_cnt", o_frame_cnt[1], 16'd0);
        check("maxlen.a_frame_len", o_frame_len[0], 16'd5);

        // four invalid words mid-frame drop the link without EOF
        drive(K_IDLE, V_IDLE, 1'b1, 1'b0);
        clear_tallies();
        w(K_CTRL, V_SOF); w(K_DATA, 16'd0); w(K_DATA, 16'd1);
        repeat (4) w(K_BAD, 16'h1234);
        settle(K_DATA, 16'h0000);
        check("loss.link_up", 16'(o_link_up[0]), 16'd0);
        check("loss.eof_cnt", 16'(n_eof[0]), 16'd0);
        check("loss.err_cnt", o_err_cnt[0], 16'd4);

        // resync, then clear on the EOF word beats the frame increment
        idle(4);
        w(K_CTRL, V_SOF); w(K_DATA, 16'd0);
        drive(K_CTRL, V_EOF, 1'b1, 1'b0);
        settle(K_IDLE, V_IDLE);
        check("clr.frame_cnt", o_frame_cnt[0], 16'd0);
        check("clr.err_cnt", o_err_cnt[0], 16'd0);
        check("clr.frame_len", o_frame_len[0], 16'd1);
        check("clr.link_up", 16'(o_link_up[0]), 16'd1);

        // reset mid-frame, then a clean frame
        w(K_CTRL, V_SOF); w(K_DATA, 16'd0); w(K_DATA, 16'd1);
        repeat (2) drive(K_DATA, 16'h0000, 1'b0, 1'b1);
        idle(4);
        clear_tallies();
        w(K_CTRL, V_SOF);
        for (int v = 0; v < 4; v++) w(K_DATA, 16'(v));
        w(K_CTRL, V_EOF);
        settle(K_IDLE, V_IDLE);
        check("rstmid.frame_cnt", o_frame_cnt[0], 16'd1);
        check("rstmid.err_cnt", o_err_cnt[0], 16'd0);
        check("rstmid.eof_cnt", 16'(n_eof[0]), 16'd1);
        check("rstmid.valid_cnt", 16'(n_valid[0]), 16'd4);
        check("rstmid.frame_len", o_frame_len[0], 16'd4);

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
